// File: rtl/ddr_par_pkg.sv
// rtl/ddr_par_pkg.sv - shared DDR command-state encodings and timing defaults
// Shared with the DDR signal generator, which decodes cstate into pin activity.
package ddr_par;

    typedef enum logic [3:0] {
        C_IDLE   = 4'd0,
        C_ACTIVE = 4'd1,
        C_TRCD   = 4'd2,
        C_READA  = 4'd3,
        C_CL     = 4'd4,
        C_RDATA  = 4'd5,
        C_WRITEA = 4'd6,
        C_WDATA  = 4'd7,
        C_AR     = 4'd8,
        C_TRFC   = 4'd9
    } cstate_t;

    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_T_RCD   = 2;
    localparam int DEF_CL      = 2;
    localparam int DEF_BL      = 4;
    localparam int DEF_T_WR_RP = 4;
    localparam int DEF_T_RFC   = 8;
    localparam int DEF_REF_INT = 780;

    localparam int CNT_W = 8;

    // Phase counters count down to zero, so an n-cycle phase loads n-1.
    function automatic logic [CNT_W-1:0] load_val(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ddr_ref_timer.sv
// rtl/ddr_ref_timer.sv - refresh interval counter with saturating pending count
// Pending refreshes clear whenever the scheduler is disabled; overrun is sticky until reset.
module ddr_ref_timer
    import ddr_par::*;
#(
    parameter int REF_INT = DEF_REF_INT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_ar_start,
    output logic [1:0] o_pending,
    output logic       o_overrun
);

    localparam int            RW     = (REF_INT > 1) ? $clog2(REF_INT) : 1;
    localparam logic [RW-1:0] RELOAD = RW'(REF_INT - 1);

    logic [RW-1:0] r_cnt;
    logic [1:0]    r_pending;
    logic          r_overrun;
    logic          w_inc;
    logic          w_dec;

    assign w_inc = i_enable && (r_cnt == '0);
    assign w_dec = i_enable && i_ar_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= RELOAD;
            r_pending <= 2'd0;
            r_overrun <= 1'b0;
        end else if (!i_enable) begin
            r_cnt     <= RELOAD;
            r_pending <= 2'd0;
        end else begin
            r_cnt <= w_inc ? RELOAD : r_cnt - 1'b1;
            if (w_inc && (r_pending == 2'd3))
                r_overrun <= 1'b1;
            // Simultaneous expiry and service cancel out.
            if (w_inc && !w_dec && (r_pending != 2'd3))
                r_pending <= r_pending + 2'd1;
            else if (!w_inc && w_dec && (r_pending != 2'd0))
                r_pending <= r_pending - 2'd1;
        end
    end

    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/ddr_cmd_sched.sv
// rtl/ddr_cmd_sched.sv - DDR command scheduler: refresh-first, round-robin read/write
// Every decision is taken in C_IDLE; commands run as fixed-length auto-precharge sequences.
module ddr_cmd_sched
    import ddr_par::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int T_RCD   = DEF_T_RCD,
    parameter int CL      = DEF_CL,
    parameter int BL      = DEF_BL,
    parameter int T_WR_RP = DEF_T_WR_RP,
    parameter int T_RFC   = DEF_T_RFC,
    parameter int REF_INT = DEF_REF_INT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ack,
    output logic              wr_strobe,
    output logic [3:0]        cstate,
    output logic [ADDR_W-1:0] addr,
    output logic              ref_overrun
);

    localparam logic [CNT_W-1:0] L_RCD   = load_val(T_RCD);
    localparam logic [CNT_W-1:0] L_CL    = load_val(CL);
    localparam logic [CNT_W-1:0] L_RDATA = load_val(BL / 2);
    localparam logic [CNT_W-1:0] L_WDATA = load_val(BL / 2 + T_WR_RP);
    localparam logic [CNT_W-1:0] L_WREC  = CNT_W'(T_WR_RP);
    localparam logic [CNT_W-1:0] L_RFC   = load_val(T_RFC);

    cstate_t           r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_wr;
    logic              r_wr_turn;
    logic              r_rd_ack;
    logic              r_wr_ack;
    logic              r_rd_valid;
    logic              r_wr_strobe;
    logic [ADDR_W-1:0] r_addr;

    logic [1:0] w_pending;
    logic       w_ar_start;
    logic       w_rd_win;
    logic       w_wr_win;

    assign w_ar_start = init_done && (r_state == C_IDLE) && (w_pending != 2'd0);
    // r_wr_turn is set after a read grant so the writer wins the next tie.
    assign w_rd_win   = rd_req && (!wr_req || !r_wr_turn);
    assign w_wr_win   = wr_req && !w_rd_win;

    ddr_ref_timer #(
        .REF_INT(REF_INT)
    ) u_ref (
        .clk       (clk),
        .rst       (reset),
        .i_enable  (init_done),
        .i_ar_start(w_ar_start),
        .o_pending (w_pending),
        .o_overrun (ref_overrun)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= C_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_wr_turn   <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_addr      <= '0;
        end else if (!init_done) begin
            r_state     <= C_IDLE;
            r_rd_ack    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_wr_strobe <= 1'b0;
        end else begin
            r_rd_ack <= 1'b0;
            r_wr_ack <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (w_pending != 2'd0) begin
                        r_state <= C_AR;
                    end else if (w_rd_win) begin
                        r_state   <= C_ACTIVE;
                        r_rd_ack  <= 1'b1;
                        r_addr    <= rd_addr;
                        r_is_wr   <= 1'b0;
                        r_wr_turn <= 1'b1;
                    end else if (w_wr_win) begin
                        r_state   <= C_ACTIVE;
                        r_wr_ack  <= 1'b1;
                        r_addr    <= wr_addr;
                        r_is_wr   <= 1'b1;
                        r_wr_turn <= 1'b0;
                    end
                end
                C_ACTIVE: begin
                    r_state <= C_TRCD;
                    r_cnt   <= L_RCD;
                end
                C_TRCD: begin
                    if (r_cnt == '0)
                        r_state <= r_is_wr ? C_WRITEA : C_READA;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                C_READA: begin
                    r_state <= C_CL;
                    r_cnt   <= L_CL;
                end
                C_CL: begin
                    if (r_cnt == '0) begin
                        r_state    <= C_RDATA;
                        r_cnt      <= L_RDATA;
                        r_rd_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                C_RDATA: begin
                    if (r_cnt == '0) begin
                        r_state    <= C_IDLE;
                        r_rd_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                C_WRITEA: begin
                    r_state     <= C_WDATA;
                    r_cnt       <= L_WDATA;
                    r_wr_strobe <= 1'b1;
                end
                C_WDATA: begin
                    // The tail of the phase is write recovery plus precharge: no data.
                    if (r_cnt == L_WREC)
                        r_wr_strobe <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state     <= C_IDLE;
                        r_wr_strobe <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                C_AR: begin
                    r_state <= C_TRFC;
                    r_cnt   <= L_RFC;
                end
                C_TRFC: begin
                    if (r_cnt == '0)
                        r_state <= C_IDLE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign cstate    = r_state;
    assign addr      = r_addr;
    assign rd_ack    = r_rd_ack;
    assign wr_ack    = r_wr_ack;
    assign rd_valid  = r_rd_valid;
    assign wr_strobe = r_wr_strobe;

endmodule
